// File: rtl/inertial_delay_filter.sv
// Clocked inertial-delay filter: data_out follows data_in only after DELAY stable samples.
// Optional `REJECT_COUNT_EN adds a saturating reject_count output.
module inertial_delay_filter #(
  parameter int              WIDTH     = 2,
  parameter int              DELAY     = 10,
  parameter int              CNT_W     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             pending,
  output logic             update_pulse
`ifdef REJECT_COUNT_EN
  ,
  output logic [CNT_W-1:0] reject_count
`endif
);

  typedef enum logic {
    IDLE,
    PENDING
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state, next_state;
  logic [WIDTH-1:0] cand, next_cand;
  logic [CNT_W-1:0] count, next_count;
  logic [WIDTH-1:0] next_out;
  logic             next_upd;

  // state and datapath registers, reset has priority
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cand         <= RESET_VAL;
      count        <= '0;
      data_out     <= RESET_VAL;
      update_pulse <= 1'b0;
    end else begin
      state        <= next_state;
      cand         <= next_cand;
      count        <= next_count;
      data_out     <= next_out;
      update_pulse <= next_upd;
    end
  end

  // next-state: time a candidate, commit it or drop it on deviation
  always_comb begin
    next_state = state;
    next_cand  = cand;
    next_count = count;
    next_out   = data_out;
    next_upd   = 1'b0;
    unique case (state)
      IDLE: begin
        if (data_in != data_out) begin
          if (DELAY == 1) begin
            next_out = data_in;
            next_upd = 1'b1;
          end else begin
            next_cand  = data_in;
            next_count = ONE;
            next_state = PENDING;
          end
        end
      end
      PENDING: begin
        if (data_in == cand) begin
          if (count == LAST) begin
            next_out   = cand;
            next_upd   = 1'b1;
            next_count = '0;
            next_state = IDLE;
          end else begin
            next_count = count + ONE;
          end
        end else if (data_in == data_out) begin
          next_count = '0;
          next_state = IDLE;
        end else begin
          next_cand  = data_in;
          next_count = ONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign pending = (state == PENDING);

`ifdef REJECT_COUNT_EN
  logic reject;
  assign reject = (state == PENDING) && (data_in != cand);

  // count abandoned candidates, sticking at all-ones
  always_ff @(posedge clock) begin
    if (reset)
      reject_count <= '0;
    else if (reject && (reject_count != '1))
      reject_count <= reject_count + ONE;
  end
`endif

endmodule

// File: tb/tb_inertial_delay_filter.sv
// Randomized bench for inertial_delay_filter: three instances (DELAY 10, 1, 3/CNT_W 4)
// share one input stream and are checked against a run-length reference model.
module tb_inertial_delay_filter;

  logic       clk;
  logic       reset;
  logic [1:0] data_in;

  logic [1:0] dout [3];
  logic       pend [3];
  logic       upd  [3];
`ifdef REJECT_COUNT_EN
  logic [15:0] rc0;
  logic [15:0] rc1;
  logic [3:0]  rc2;
`endif

  inertial_delay_filter #(.WIDTH(2), .DELAY(10), .CNT_W(16)) u_main (
    .clock(clk), .reset(reset), .data_in(data_in),
    .data_out(dout[0]), .pending(pend[0]), .update_pulse(upd[0])
`ifdef REJECT_COUNT_EN
    , .reject_count(rc0)
`endif
  );

  inertial_delay_filter #(.WIDTH(2), .DELAY(1), .CNT_W(16)) u_d1 (
    .clock(clk), .reset(reset), .data_in(data_in),
    .data_out(dout[1]), .pending(pend[1]), .update_pulse(upd[1])
`ifdef REJECT_COUNT_EN
    , .reject_count(rc1)
`endif
  );

  inertial_delay_filter #(.WIDTH(2), .DELAY(3), .CNT_W(4)) u_sat (
    .clock(clk), .reset(reset), .data_in(data_in),
    .data_out(dout[2]), .pending(pend[2]), .update_pulse(upd[2])
`ifdef REJECT_COUNT_EN
    , .reject_count(rc2)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference: output takes a new value once the current run of identical
  // samples since reset reaches DELAY; a reject is any change of sample
  // while the previous sample differed from the output
  int         m_dly  [3] = '{10, 1, 3};
  int         m_rmax [3] = '{65535, 65535, 15};
  logic [1:0] m_out  [3];
  logic [1:0] m_prev [3];
  bit         m_has  [3];
  int         m_run  [3];
  int         m_rej  [3];
  bit         m_upd  [3];
  bit         m_pend [3];

  task automatic model_step(input int i, input logic [1:0] s, input logic r);
    bit was_pend;
    if (r) begin
      m_out[i]  = 2'b00;
      m_has[i]  = 1'b0;
      m_run[i]  = 0;
      m_rej[i]  = 0;
      m_upd[i]  = 1'b0;
      m_pend[i] = 1'b0;
      return;
    end
    was_pend = m_has[i] && (m_prev[i] != m_out[i]);
    if (was_pend && (s != m_prev[i]) && (m_rej[i] < m_rmax[i]))
      m_rej[i]++;
    if (m_has[i] && (s == m_prev[i]))
      m_run[i] = (m_run[i] < 1000) ? m_run[i] + 1 : m_run[i];
    else
      m_run[i] = 1;
    m_upd[i] = (s != m_out[i]) && (m_run[i] >= m_dly[i]);
    if (m_upd[i])
      m_out[i] = s;
    m_prev[i] = s;
    m_has[i]  = 1'b1;
    m_pend[i] = (s != m_out[i]);
  endtask

  task automatic step(input logic [1:0] d, input logic r);
    @(negedge clk);
    data_in = d;
    reset   = r;
    @(posedge clk);
    for (int i = 0; i < 3; i++)
      model_step(i, d, r);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("out%0d", i), 32'(dout[i]), 32'(m_out[i]));
      check($sformatf("pend%0d", i), 32'(pend[i]), 32'(m_pend[i]));
      check($sformatf("upd%0d", i), 32'(upd[i]), 32'(m_upd[i]));
    end
`ifdef REJECT_COUNT_EN
    check("rc0", 32'(rc0), 32'(m_rej[0]));
    check("rc1", 32'(rc1), 32'(m_rej[1]));
    check("rc2", 32'(rc2), 32'(m_rej[2]));
`endif
  endtask

  initial begin
    int n;
    int len;
    logic [1:0] v;
    n_chk   = 0;
    n_fail  = 0;
    reset   = 1'b1;
    data_in = 2'b00;

    step(2'b00, 1'b1);
    step(2'b00, 1'b1);
    check("rst_out", 32'(dout[0]), 32'd0);
    check("rst_pend", 32'(pend[0]), 32'd0);

    // stable 10 for ten samples
    for (int k = 0; k < 9; k++) begin
      step(2'b10, 1'b0);
      check("t1_hold", 32'(dout[0]), 32'd0);
      check("t1_pend", 32'(pend[0]), 32'd1);
    end
    step(2'b10, 1'b0);
    check("t1_out", 32'(dout[0]), 32'd2);
    check("t1_upd", 32'(upd[0]), 32'd1);
    step(2'b10, 1'b0);
    check("t1_upd_once", 32'(upd[0]), 32'd0);

    // short excursion returning to the output value
    step(2'b11, 1'b0);
    step(2'b11, 1'b0);
    check("t2_pend", 32'(pend[0]), 32'd1);
    step(2'b10, 1'b0);
    check("t2_out", 32'(dout[0]), 32'd2);
    check("t2_upd", 32'(upd[0]), 32'd0);
`ifdef REJECT_COUNT_EN
    check("t2_rc", 32'(rc0), 32'd1);
`endif

    // short excursion followed by a different value: restart
    step(2'b11, 1'b0);
    step(2'b11, 1'b0);
    for (int k = 0; k < 9; k++) begin
      step(2'b00, 1'b0);
      check("t3_hold", 32'(dout[0]), 32'd2);
    end
    step(2'b00, 1'b0);
    check("t3_out", 32'(dout[0]), 32'd0);
    check("t3_upd", 32'(upd[0]), 32'd1);
`ifdef REJECT_COUNT_EN
    check("t3_rc", 32'(rc0), 32'd2);
`endif

    // reset in the middle of timing a candidate
    for (int k = 0; k < 5; k++)
      step(2'b01, 1'b0);
    step(2'b01, 1'b1);
    check("t4_out", 32'(dout[0]), 32'd0);
    check("t4_pend", 32'(pend[0]), 32'd0);
    check("t4_upd", 32'(upd[0]), 32'd0);

    // one-cycle pulses: saturation on the 4-bit counter
    step(2'b00, 1'b1);
    for (int k = 0; k < 20; k++) begin
      step(2'b01, 1'b0);
      check("t5_follow", 32'(dout[1]), 32'd1);
      step(2'b00, 1'b0);
    end
    check("t6_out", 32'(dout[2]), 32'd0);
`ifdef REJECT_COUNT_EN
    check("t6_rc", 32'(rc2), 32'd15);
    check("t5_rc", 32'(rc1), 32'd0);
`endif

    // random holds of varying length with rare resets
    n = 0;
    while (n < 3000) begin
      v   = 2'($urandom);
      len = $urandom_range(1, 14);
      for (int j = 0; j < len; j++)
        step(v, ($urandom_range(0, 199) == 0));
      n += len;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
